wave_pwm_out: RTL and testbench
===============================

# wave_pwm_out

Output stage directly downstream of the waveform peripheral: accepts 8-bit waveform samples over a valid/ready handshake, buffers them in a small FIFO, and converts each sample to a 1-bit output using either PWM or first-order sigma-delta modulation. A new sample is consumed once per 256-tick output frame. The single-bit result drives one dedicated output pin for off-chip RC filtering.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  8  unsigned sample (duty), 0..255.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample; equals !full.
- enable  in  1  modulator run enable.
- mode  in  1  0 = PWM, 1 = sigma-delta.
- prescale  in  8  tick period minus one; a tick occurs every prescale+1 cycles.
- pwm_out  out  1  registered modulated output.
- underrun  out  1  one-cycle pulse when a frame boundary finds the FIFO empty.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push**
  - A push occurs when sample_valid && sample_ready.
  - sample_ready is computed from registered occupancy only, so there is no combinational path from the pop.
- **Prescaler**
  - presc_cnt (8 bit) runs only while enable = 1.
  - When presc_cnt >= prescale: raise tick and load 0. Otherwise increment.
  - The >= comparison ensures that lowering prescale mid-count never produces a full 256-cycle stall.
- **Phase and frame boundary**
  - phase (8 bit) increments on each tick and wraps 255 -> 0.
  - The tick on which phase goes from 255 to 0 is the frame boundary.
- **Duty update at the frame boundary**
  - If the FIFO is not empty: pop the head into duty.
  - If the FIFO is empty: keep the old duty and pulse underrun.
- **PWM mode (mode = 0)**
  - pwm_out_next = (phase < duty).
  - duty 0 gives a constant low output; duty 255 gives high for 255 of 256 ticks.
- **Sigma-delta mode (mode = 1)**
  - On each tick, compute {carry, acc} = acc + duty (9-bit sum); pwm_out_next = carry.
  - Between ticks, pwm_out holds its value.
- **enable = 0**
  - presc_cnt, phase and acc are cleared to 0; pwm_out = 0.
  - No pops and no underrun.
  - Pushes are still accepted, so software can prefill the FIFO.
- **First frame after enable rises**
  - The first tick occurs prescale+1 cycles after the rising edge.
  - The frame uses the current duty register (0 after reset).
  - The first pop happens at the first 255 -> 0 wrap.
- **Simultaneous events**
  - Push and pop in the same cycle: occupancy is unchanged, and the pop returns the old head.
  - Push into an empty FIFO on a boundary cycle: underrun fires and the pushed sample is stored for the next frame.
  - Full FIFO on a boundary cycle: sample_ready = 0 that cycle and becomes 1 on the next cycle.
- **mode change**
  - Takes effect on the next tick.
  - acc is not cleared.

## Timing
- Reset values:
  - pwm_out = 0, underrun = 0, fifo_level = 0, sample_ready = 1.
  - duty, acc, phase and presc_cnt are all 0.
- **Reset mid-operation**
  - Asynchronously clears all of the above, including FIFO contents and pointers.
- **Output latency**
  - pwm_out is registered and reflects a phase/acc value one cycle after the tick that produced it.
  - underrun is asserted in the cycle after the boundary tick.
- **Push latency**
  - fifo_level and sample_ready update on the clock edge after the push.
- **Frame length**
  - 256 × (prescale+1) cycles while enable = 1.

## Test plan
- **Reset**
  - Stimulus: assert rst mid-frame with 3 samples queued.
  - Required response: pwm_out = 0, fifo_level = 0 and sample_ready = 1 immediately, before any clock edge.
- **PWM duty**
  - Stimulus: prescale = 0, push 64, enable.
  - Required response: after the first boundary, each 256-cycle frame has exactly 64 high cycles, which are the first 64 phases.
- **Sigma-delta mode**
  - Stimulus: mode = 1, prescale = 1, duty 128.
  - Required response: pwm_out alternates, holding each level for 2 cycles; 128 ones per 256 ticks.
- **Full FIFO**
  - Stimulus: enable = 0, push 5 samples with DEPTH = 4.
  - Required response: the 5th is refused (sample_ready = 0, fifo_level = 4). After enable, pops occur in order, one per 256-cycle frame.
- **Underrun**
  - Stimulus: enable with an empty FIFO.
  - Required response: underrun pulses once per frame boundary and duty holds its last value.
  - Then push on the boundary cycle: underrun still fires and the sample is used in the following frame.
- **Prescale edge**
  - Stimulus: prescale = 200, wait until presc_cnt = 150, then set prescale = 100.
  - Required response: tick on the next cycle; the counter then runs 101-cycle periods.

Source files
------------

// File: rtl/wave_pwm_out.sv
// wave_pwm_out: sample FIFO feeding a PWM / first-order sigma-delta
// single-bit modulator, one sample consumed per 256-tick frame.
module wave_pwm_out #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [7:0]             prescale,
  output logic                   pwm_out,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [7:0] presc_cnt;
  logic [7:0] phase;
  logic [7:0] duty;
  logic [7:0] acc;

  logic       empty;
  logic       push;
  logic       pop;
  logic       tick;
  logic       boundary;
  logic [8:0] sum;

  // ready depends on registered occupancy only, never on the pop
  assign empty        = (count == '0);
  assign sample_ready = (count != FULL_LVL);
  assign push         = sample_valid && sample_ready;

  // >= keeps a shrinking prescale from wrapping the counter
  assign tick     = enable && (presc_cnt >= prescale);
  assign boundary = tick && (phase == 8'hff);
  assign pop      = boundary && !empty;

  assign sum        = {1'b0, acc} + {1'b0, duty};
  assign fifo_level = count;

  // sample FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sample_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count
             + {{AW{1'b0}}, push}
             - {{AW{1'b0}}, pop};
    end
  end

  // prescaler, frame phase, duty reload and modulator output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      phase     <= '0;
      duty      <= '0;
      acc       <= '0;
      pwm_out   <= 1'b0;
      underrun  <= 1'b0;
    end else if (!enable) begin
      presc_cnt <= '0;
      phase     <= '0;
      acc       <= '0;
      pwm_out   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= boundary && empty;
      if (tick) begin
        presc_cnt <= '0;
        phase     <= phase + 8'd1;
        if (mode) begin
          acc     <= sum[7:0];
          pwm_out <= sum[8];
        end else begin
          pwm_out <= (phase < duty);
        end
        if (pop) begin
          duty <= mem[rd_ptr];
        end
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wave_pwm_out.sv
// tb_wave_pwm_out: random and directed stimulus against a
// frame/tick level reference model of the PWM output stage.
module tb_wave_pwm_out;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] prescale = '0;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail = 0;

  int m_cnt;
  int m_ph;
  int m_duty;
  int m_acc;
  bit m_pwm;
  bit m_und;
  int q[$];

  wave_pwm_out #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .enable(enable),
    .mode(mode),
    .prescale(prescale),
    .pwm_out(pwm_out),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = 0;
    m_ph   = 0;
    m_duty = 0;
    m_acc  = 0;
    m_pwm  = 1'b0;
    m_und  = 1'b0;
    q.delete();
  endfunction

  // one clock edge of the reference behaviour
  function automatic void model_step();
    int pre;
    int s;
    bit do_push;
    if (rst) begin
      model_reset();
      return;
    end
    pre     = q.size();
    do_push = sample_valid && (pre < DEPTH);
    m_und   = 1'b0;
    if (!enable) begin
      m_cnt = 0;
      m_ph  = 0;
      m_acc = 0;
      m_pwm = 1'b0;
    end else if (m_cnt >= int'(prescale)) begin
      s = m_acc + m_duty;
      if (mode) begin
        m_pwm = (s >= 256);
        m_acc = s % 256;
      end else begin
        m_pwm = (m_ph < m_duty);
      end
      if (m_ph == 255) begin
        if (pre > 0) m_duty = q.pop_front();
        else m_und = 1'b1;
      end
      m_ph  = (m_ph + 1) % 256;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    if (do_push) q.push_back(int'(sample_in));
  endfunction

  task automatic compare_all();
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("underrun", 32'(underrun), 32'(m_und));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("sample_ready", 32'(sample_ready),
          32'(q.size() < DEPTH));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int highs;
    int per;
    bit ok;
    bit last;

    model_reset();
    #1;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ready", 32'(sample_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // prefill while disabled; fifth push is refused
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in = (i == 0) ? 8'd64
                : 8'($urandom_range(129, 255));
      step();
    end
    sample_valid = 1'b0;
    check("full_ready", 32'(sample_ready), 0);
    check("full_level", 32'(fifo_level), 4);

    // PWM, duty 64, prescale 0
    mode = 1'b0;
    prescale = 8'd0;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (m_duty == 64 && m_ph == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_first_pop", 32'(ok), 1);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      highs += int'(pwm_out);
    end
    check("pwm_frame_highs", 32'(highs), 64);

    // drain the FIFO, then count underrun pulses
    for (int i = 0; i < 600; i++) step();
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      highs += int'(underrun);
    end
    check("underrun_pulses", 32'(highs), 2);

    // push exactly on a boundary with an empty FIFO
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_ph == 255 && m_cnt >= int'(prescale)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("wait_boundary", 32'(ok), 1);
    sample_valid = 1'b1;
    sample_in = 8'd200;
    step();
    sample_valid = 1'b0;
    check("boundary_underrun", 32'(underrun), 1);
    check("boundary_level", 32'(fifo_level), 1);
    for (int i = 0; i < 300; i++) step();

    // sigma-delta, prescale 1, duty 128
    mode = 1'b1;
    prescale = 8'd1;
    sample_valid = 1'b1;
    sample_in = 8'd128;
    step();
    sample_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (m_duty == 128 && m_ph == 0 && m_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_sd_pop", 32'(ok), 1);
    step();
    step();
    highs = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      highs += int'(pwm_out);
    end
    check("sd_highs", 32'(highs), 256);

    // lowering prescale below the running count
    prescale = 8'd200;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (m_cnt == 150) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_presc_150", 32'(ok), 1);
    prescale = 8'd100;
    last = pwm_out;
    step();
    check("presc_fast_tick", 32'(pwm_out != last), 1);
    last = pwm_out;
    per = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      per++;
      if (pwm_out != last) break;
    end
    check("presc_period", 32'(per), 101);

    // randomized traffic
    prescale = 8'd0;
    for (int i = 0; i < 15000; i++) begin
      sample_valid = ($urandom_range(0, 199) == 0);
      sample_in = 8'($urandom);
      if ($urandom_range(0, 1999) == 0) mode = ~mode;
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      if ($urandom_range(0, 2499) == 0)
        prescale = 8'($urandom_range(0, 3));
      step();
    end
    sample_valid = 1'b0;

    // asynchronous reset mid-frame with samples queued
    enable = 1'b1;
    mode = 1'b0;
    prescale = 8'd0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = (q.size() < DEPTH);
      sample_in = 8'd255;
      step();
    end
    sample_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (m_pwm && q.size() == 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_rst_setup", 32'(ok), 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_pwm", 32'(pwm_out), 0);
    check("async_rst_level", 32'(fifo_level), 0);
    check("async_rst_ready", 32'(sample_ready), 1);
    check("async_rst_underrun", 32'(underrun), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
